// File: rtl/pnml_lim_row.sv
// pnml_lim_row: one row of perpendicular nanomagnetic logic cells used as a
// logic-in-memory element. Commands load, read, shift/rotate the row, or apply
// a NAND/NOR with an operand through the two clocking-field phases.
//
// Ports
//   clk_i, rstn        clock, asynchronous active-low reset
//   cmd_*              command channel (valid/ready); op, phase enables, amount, fill, data
//   rsp_*              response channel (valid/ready); row contents and error flag
//   row_o              live row state
//   bz_s_o, bz_m_o     field-phase indicators (PH1 select, phase enabled)
//   current_m_o        shift-current indicator, high in every SHIFT cycle
module pnml_lim_row #(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned AMT_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rstn,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [2:0]       cmd_op_i,
    input  logic [1:0]       cmd_pol_i,
    input  logic [AMT_W-1:0] cmd_amt_i,
    input  logic             cmd_fill_i,
    input  logic [WIDTH-1:0] cmd_data_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [WIDTH-1:0] rsp_data_o,
    output logic             rsp_err_o,
    output logic [WIDTH-1:0] row_o,
    output logic             bz_s_o,
    output logic             bz_m_o,
    output logic             current_m_o
);

    typedef enum logic [2:0] {
        OP_LOAD = 3'd0,
        OP_NAND = 3'd1,
        OP_NOR  = 3'd2,
        OP_SHR  = 3'd3,
        OP_SHL  = 3'd4,
        OP_ROR  = 3'd5,
        OP_READ = 3'd6,
        OP_ILL  = 3'd7
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PH0   = 3'd1,
        S_PH1   = 3'd2,
        S_SHIFT = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] row_q, row_d;
    logic [WIDTH-1:0] snap_q, opnd_q;
    op_t              op_q;
    logic [1:0]       pol_q;
    logic             fill_q;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic             accept_c;
    logic             amt_bad_c;
    logic [WIDTH-1:0] eval_c;
    logic [WIDTH-1:0] shift_c;

    assign accept_c = cmd_valid_i && (state_q == S_IDLE);

    // Amount range check; only reachable when WIDTH is not a power of two.
    generate
        if (WIDTH == (1 << AMT_W)) begin : g_amt_full
            assign amt_bad_c = 1'b0;
        end else begin : g_amt_part
            localparam logic [AMT_W-1:0] AMT_MAX = AMT_W'(WIDTH - 1);
            assign amt_bad_c = (cmd_amt_i > AMT_MAX);
        end
    endgenerate

    // Logic evaluation uses only the values frozen at acceptance.
    assign eval_c = (op_q == OP_NOR) ? ~(snap_q | opnd_q) : ~(snap_q & opnd_q);

    // One-position move of the row for the latched shift/rotate opcode.
    always_comb begin
        shift_c = row_q;
        case (op_q)
            OP_SHR:  shift_c = {fill_q, row_q[WIDTH-1:1]};
            OP_SHL:  shift_c = {row_q[WIDTH-2:0], fill_q};
            OP_ROR:  shift_c = {row_q[0], row_q[WIDTH-1:1]};
            default: shift_c = row_q;
        endcase
    end

    // Next-state and row update.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    err_d   = 1'b0;
                    state_d = S_RESP;
                    case (op_t'(cmd_op_i))
                        OP_LOAD: row_d = cmd_data_i;
                        OP_READ: ;
                        OP_NAND, OP_NOR: state_d = S_PH0;
                        OP_SHR, OP_SHL, OP_ROR: begin
                            if (amt_bad_c) begin
                                err_d = 1'b1;
                            end else if (cmd_amt_i != '0) begin
                                state_d = S_SHIFT;
                                cnt_d   = cmd_amt_i;
                            end
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            // PH0: cells holding 1 may switch to the evaluated value.
            S_PH0: begin
                if (pol_q[0]) row_d = row_q & eval_c;
                state_d = S_PH1;
            end
            // PH1: cells holding 0 may switch to the evaluated value.
            S_PH1: begin
                if (pol_q[1]) row_d = row_q | eval_c;
                state_d = S_RESP;
            end
            S_SHIFT: begin
                row_d = shift_c;
                cnt_d = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) state_d = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, row and latched command fields.
    always_ff @(posedge clk_i or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            snap_q  <= '0;
            opnd_q  <= '0;
            op_q    <= OP_LOAD;
            pol_q   <= '0;
            fill_q  <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            if (accept_c) begin
                snap_q <= row_q;
                opnd_q <= cmd_data_i;
                op_q   <= op_t'(cmd_op_i);
                pol_q  <= cmd_pol_i;
                fill_q <= cmd_fill_i;
            end
        end
    end

    // Outputs decode registered state only.
    assign cmd_ready_o = (state_q == S_IDLE);
    assign rsp_valid_o = (state_q == S_RESP);
    assign rsp_data_o  = row_q;
    assign rsp_err_o   = (state_q == S_RESP) && err_q;
    assign row_o       = row_q;
    assign bz_s_o      = (state_q == S_PH1);
    assign bz_m_o      = ((state_q == S_PH0) && pol_q[0]) || ((state_q == S_PH1) && pol_q[1]);
    assign current_m_o = (state_q == S_SHIFT);

endmodule
